// File: rtl/klp32_mem_pkg.sv
// Shared definitions for the KLP32 data memory: load/store size codes,
// controller states and the request size legality check.
package klp32_mem_pkg;

   // RISC-V funct3 load/store size encodings
   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   // Controller states: zero-fill sweep, ready for a request, access in flight
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   // Loads accept all five sizes; stores only B, H and W
   function automatic logic size_ok(input logic we, input logic [2:0] size);
      logic ok;
      unique case (size)
         MEM_B, MEM_H, MEM_W: ok = 1'b1;
         MEM_BU, MEM_HU:      ok = ~we;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data memory: store lane enables and data
// replication, load lane extraction with sign/zero extension, and the
// alignment check for halfword/word accesses.
module mem_align
   import klp32_mem_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic [1:0]  lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Select the addressed byte and halfword out of the stored word
   always_comb begin
      unique case (lo_i)
         2'd0:    byte_v = rword_i[7:0];
         2'd1:    byte_v = rword_i[15:8];
         2'd2:    byte_v = rword_i[23:16];
         default: byte_v = rword_i[31:24];
      endcase
      half_v = lo_i[1] ? rword_i[31:16] : rword_i[15:0];
   end

   // Lane enables, replicated store data, extended load data, misalignment
   always_comb begin
      be_o       = '0;
      wword_o    = wdata_i;
      rdata_o    = '0;
      misalign_o = 1'b0;
      unique case (size_i)
         MEM_B: begin
            be_o    = 4'b0001 << lo_i;
            wword_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{byte_v[7]}}, byte_v};
         end
         MEM_BU: begin
            rdata_o = {24'd0, byte_v};
         end
         MEM_H: begin
            be_o       = lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o    = {2{wdata_i[15:0]}};
            rdata_o    = {{16{half_v[15]}}, half_v};
            misalign_o = lo_i[0];
         end
         MEM_HU: begin
            rdata_o    = {16'd0, half_v};
            misalign_o = lo_i[0];
         end
         MEM_W: begin
            be_o       = 4'b1111;
            rdata_o    = rword_i;
            misalign_o = (lo_i != 2'd0);
         end
         default: begin
            be_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// KLP32 data memory controller: valid/ready request port, fixed wait-state
// latency, byte/halfword/word load/store with fault detection, and a
// zero-fill sweep of the array after every reset.
module data_mem_ctrl
   import klp32_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        init_done
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_e          state_q, state_d;
   logic [AW-1:0]   ptr_q;
   logic [2:0]      cnt_q;
   logic            we_q;
   logic [2:0]      size_q;
   logic [AW-1:0]   idx_q;
   logic [1:0]      lo_q;
   logic [31:0]     wdata_q;
   logic            pre_fault_q;
   logic            init_done_q;
   logic            rsp_valid_q;
   logic [31:0]     rsp_rdata_q;
   logic            rsp_fault_q;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            accept;
   logic            fire;
   logic            sweep_last;
   logic            range_bad;
   logic [31:0]     rword;
   logic [3:0]      be;
   logic [31:0]     wword;
   logic [31:0]     rext;
   logic            misalign;
   logic            fault_now;
   logic            wr_en;

   assign req_ready  = (state_q == ST_IDLE);
   assign accept     = req_ready && req_valid;
   assign fire       = (state_q == ST_WAIT) && (cnt_q == 3'd0);
   assign sweep_last = (state_q == ST_INIT) && (ptr_q == AW'(DEPTH_WORDS - 1));
   assign range_bad  = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign rword      = mem[idx_q];

   mem_align u_align (
      .size_i     (size_q),
      .lo_i       (lo_q),
      .wdata_i    (wdata_q),
      .rword_i    (rword),
      .be_o       (be),
      .wword_o    (wword),
      .rdata_o    (rext),
      .misalign_o (misalign)
   );

   // Size/range faults are latched at capture; misalignment is derived from
   // the captured size and low address bits, which hold until the access fires.
   assign fault_now = pre_fault_q | misalign;
   assign wr_en     = fire && we_q && !fault_now;

   // Next-state selection for the sweep / idle / wait sequence
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT: if (sweep_last) state_d = ST_IDLE;
         ST_IDLE: if (accept)     state_d = ST_WAIT;
         ST_WAIT: if (fire)       state_d = ST_IDLE;
         default:                 state_d = ST_INIT;
      endcase
   end

   // FSM, sweep pointer, wait counter, request capture and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         ptr_q       <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         size_q      <= '0;
         idx_q       <= '0;
         lo_q        <= '0;
         wdata_q     <= '0;
         pre_fault_q <= 1'b0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= 1'b0;
         if (state_q == ST_INIT) begin
            ptr_q <= ptr_q + 1'b1;
         end
         if (sweep_last) begin
            init_done_q <= 1'b1;
         end
         if (accept) begin
            cnt_q       <= 3'(WAIT_STATES);
            we_q        <= req_we;
            size_q      <= req_size;
            idx_q       <= req_addr[AW+1:2];
            lo_q        <= req_addr[1:0];
            wdata_q     <= req_wdata;
            pre_fault_q <= !size_ok(req_we, req_size) || range_bad;
         end else if ((state_q == ST_WAIT) && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (fire) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= fault_now;
            rsp_rdata_q <= (we_q || fault_now) ? '0 : rext;
         end
      end
   end

   // Array writes: zero-fill during the sweep, lane-masked stores otherwise
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem[ptr_q] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx_q][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver pushes hand-computed
// responses with their due cycle, a monitor pops and compares on rsp_valid.
module tb_data_mem_ctrl;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WS    = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int unsigned cyc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        init_done;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   exp_t        sb[$];

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
            chk({e.name, "_fault"}, {31'd0, rsp_fault}, {31'd0, e.fault});
            chk({e.name, "_cycle"}, cyc, e.cyc);
         end
      end
   end

   task automatic wait_ready();
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_req(input string name, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_fault,
                         input bit expect_rsp);
      exp_t e;
      wait_ready();
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      if (expect_rsp) begin
         e.rdata = exp_rdata;
         e.fault = exp_fault;
         e.cyc   = cyc + WS + 1;
         e.name  = name;
         sb.push_back(e);
      end
      req_valid = 1'b0;
      req_we    = ~we;
      req_size  = 3'($urandom_range(0, 7));
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", sb.size(), 32'd0);
   endtask

   task automatic sweep_and_count(input string name);
      int unsigned n;
      bit early;
      n = 0;
      early = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!init_done && req_ready) early = 1'b1;
      end while (!init_done && n < DEPTH + 20);
      chk({name, "_init_cycles"}, n, DEPTH);
      chk({name, "_ready_early"}, {31'd0, early}, 32'd0);
      chk({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached with %0d checks", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      sweep_and_count("first");

      //      name          we    size    addr              wdata         exp rdata     flt
      do_req("sw_4",        1'b1, 3'b010, 32'h4,            32'hDEADBEEF, 32'h0,        1'b0, 1);
      do_req("lw_4",        1'b0, 3'b010, 32'h4,            32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_req("sw_8",        1'b1, 3'b010, 32'h8,            32'h12345678, 32'h0,        1'b0, 1);
      do_req("sb_9",        1'b1, 3'b000, 32'h9,            32'hFFFFFF80, 32'h0,        1'b0, 1);
      do_req("lw_8",        1'b0, 3'b010, 32'h8,            32'h0,        32'h12348078, 1'b0, 1);
      do_req("lb_9",        1'b0, 3'b000, 32'h9,            32'h0,        32'hFFFFFF80, 1'b0, 1);
      do_req("lbu_9",       1'b0, 3'b100, 32'h9,            32'h0,        32'h00000080, 1'b0, 1);
      do_req("lhu_a",       1'b0, 3'b101, 32'hA,            32'h0,        32'h00001234, 1'b0, 1);
      do_req("lh_3",        1'b0, 3'b001, 32'h3,            32'h0,        32'h0,        1'b1, 1);
      do_req("sw_6",        1'b1, 3'b010, 32'h6,            32'h55555555, 32'h0,        1'b1, 1);
      do_req("lw_4_again",  1'b0, 3'b010, 32'h4,            32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_req("lw_range",    1'b0, 3'b010, 32'(4 * DEPTH),   32'h0,        32'h0,        1'b1, 1);
      do_req("size_011",    1'b0, 3'b011, 32'h0,            32'h0,        32'h0,        1'b1, 1);
      do_req("sbu_store",   1'b1, 3'b100, 32'h4,            32'h000000AA, 32'h0,        1'b1, 1);
      do_req("lw_4_kept",   1'b0, 3'b010, 32'h4,            32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_req("lw_c",        1'b0, 3'b010, 32'hC,            32'h0,        32'h0,        1'b0, 1);
      do_req("sh_12",       1'b1, 3'b001, 32'h12,           32'hAAAA7FFF, 32'h0,        1'b0, 1);
      do_req("lh_12",       1'b0, 3'b001, 32'h12,           32'h0,        32'h00007FFF, 1'b0, 1);
      do_req("lw_10",       1'b0, 3'b010, 32'h10,           32'h0,        32'h7FFF0000, 1'b0, 1);
      do_req("sh_14",       1'b1, 3'b001, 32'h14,           32'h00008001, 32'h0,        1'b0, 1);
      do_req("lh_14",       1'b0, 3'b001, 32'h14,           32'h0,        32'hFFFF8001, 1'b0, 1);
      drain();

      // Accept a store, then reset while it waits: no write, no response
      do_req("sw_10_abort", 1'b1, 3'b010, 32'h10,           32'hCAFEF00D, 32'h0,        1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
      sweep_and_count("second");
      do_req("lw_10_after", 1'b0, 3'b010, 32'h10,           32'h0,        32'h0,        1'b0, 1);
      do_req("lw_4_after",  1'b0, 3'b010, 32'h4,            32'h0,        32'h0,        1'b0, 1);
      drain();
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
